cg_vector_bank: RTL

CG_VECTOR_BANK -- requirements
Module: cg_vector_bank

---
 rtl/cg_vector_bank.sv | 100 ++++++++++
 1 files changed

// File: rtl/cg_vector_bank.sv
// Double-buffered chunk store: the ALU fills the new bank while readers stream the current bank; swap exchanges them.
// Latency: rd_data/rd_valid one cycle after rd_req; fill_done/full one cycle after the final write.
// No backpressure: writes while full and swaps while filling are dropped and latch err. Option: CG_VECTOR_BANK_ZERO_PAD_EN.
module cg_vector_bank #(
    parameter int number_of_equations_per_cluster = 10,
    parameter int element_width                   = 64,
    parameter int no_of_units                     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en,
    input  logic [element_width*no_of_units-1:0] wr_data,
    input  logic                                 rd_req,
    output logic [element_width*no_of_units-1:0] rd_data,
    output logic                                 rd_valid,
    input  logic                                 swap,
    output logic                                 fill_done,
    output logic                                 full,
    output logic                                 cur_bank,
    output logic                                 err
);

    localparam int total  = number_of_equations_per_cluster +
                            (no_of_units - number_of_equations_per_cluster % no_of_units);
    localparam int chunks = total / no_of_units;
    localparam int W      = element_width * no_of_units;
    localparam int PW     = (chunks > 1) ? $clog2(chunks) : 1;

    localparam logic [0:0] FILLING = 1'b0;
    localparam logic [0:0] FULL    = 1'b1;

    logic [0:0]    state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  bank_mem [0:1][0:chunks-1];
    logic [W-1:0]  wr_word;

    logic wr_accept;
    logic swap_accept;
    logic last_wr;

    assign wr_accept   = wr_en && (state == FILLING);
    assign swap_accept = swap && (state == FULL);
    assign last_wr     = wr_accept && (wr_ptr == PW'(chunks - 1));
    assign full        = (state == FULL);

`ifdef CG_VECTOR_BANK_ZERO_PAD_EN
    // Lanes beyond the vector length are padding and are stored as zero.
    always_comb begin
        wr_word = wr_data;
        for (int lane = 0; lane < no_of_units; lane++) begin
            if (int'(wr_ptr) * no_of_units + lane >= number_of_equations_per_cluster)
                wr_word[lane*element_width +: element_width] = '0;
        end
    end
`else
    assign wr_word = wr_data;
`endif

    // Bank storage is deliberately not reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && wr_accept)
            bank_mem[~cur_bank][wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILLING;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cur_bank  <= 1'b0;
            err       <= 1'b0;
            fill_done <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            fill_done <= last_wr;
            rd_valid  <= rd_req;
            if (rd_req)
                rd_data <= bank_mem[cur_bank][rd_ptr];
            err <= err | (swap && (state == FILLING)) | (wr_en && (state == FULL));

            if (swap_accept) begin
                // A read in the swap cycle already used the old bank above.
                state    <= FILLING;
                cur_bank <= ~cur_bank;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (last_wr)
                    state <= FULL;
                if (wr_accept)
                    wr_ptr <= last_wr ? '0 : wr_ptr + PW'(1);
                if (rd_req)
                    rd_ptr <= (rd_ptr == PW'(chunks - 1)) ? '0 : rd_ptr + PW'(1);
            end
        end
    end

endmodule
